// File: rtl/rsa_pkg.sv
// Shared types and constants for the RSA operand sequencer slice.
package rsa_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    START,
    WAIT,
    UNLOAD
  } state_t;

  localparam logic [1:0] OPER_C = 2'd0;
  localparam logic [1:0] OPER_D = 2'd1;
  localparam logic [1:0] OPER_N = 2'd2;

  localparam int unsigned BYTES = 512 / 8;

endpackage

// File: rtl/rsa_result_serializer.sv
// Captures the modexp result and streams it out MSB byte first over a valid/ready handshake.
module rsa_result_serializer #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned OPER_W = 512
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              abort,
  input  logic              load,
  input  logic [OPER_W-1:0] core_result,
  input  logic              active,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              done
);

  localparam int unsigned NBYTES = OPER_W / DATA_W;
  localparam int unsigned CNT_W  = $clog2(NBYTES);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NBYTES - 1);

  logic [OPER_W-1:0] res_q;
  logic [CNT_W-1:0]  cnt;
  logic              hs;

  // Valid is masked during abort so downstream never sees a transfer that cycle.
  assign out_valid = active & ~abort;
  assign hs        = out_valid & out_ready;
  assign out_data  = res_q[OPER_W-1 -: DATA_W];
  assign done      = hs & (cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_q <= '0;
    end else if (load) begin
      res_q <= core_result;
    end else if (hs) begin
      res_q <= res_q << DATA_W;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (abort) begin
      cnt <= '0;
    end else if (hs) begin
      cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/rsa_operand_sequencer.sv
// Steers a byte stream into the C/D/N shifters, starts the modexp core and serialises its result.
// Optional WAIT timeout enabled by defining RSA_SEQ_TIMEOUT_EN.
module rsa_operand_sequencer
  import rsa_pkg::*;
#(
  parameter int unsigned DATA_W         = 8,
  parameter int unsigned OPER_W         = 512,
  parameter int unsigned TIMEOUT_CYCLES = 2**20
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              abort,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic [2:0]        shift_en,
  output logic [DATA_W-1:0] shift_data,
  output logic              core_start,
  input  logic              core_done,
  input  logic [OPER_W-1:0] core_result,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              busy,
  output logic              err
);

  localparam int unsigned NBYTES = OPER_W / DATA_W;
  localparam int unsigned CNT_W  = $clog2(NBYTES);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NBYTES - 1);

  state_t           state, state_nx;
  logic [1:0]       oper_idx;
  logic [CNT_W-1:0] byte_cnt;
  logic             in_ready_q;
  logic             core_start_q;
  logic             accept;
  logic             ser_load;
  logic             ser_done;
  logic             timeout;

  assign accept     = in_valid & in_ready_q & ~abort;
  assign shift_en   = accept ? (3'b001 << oper_idx) : 3'b000;
  assign shift_data = in_data;
  assign in_ready   = in_ready_q;
  assign core_start = core_start_q;
  assign busy       = (state != IDLE);
  assign ser_load   = (state == WAIT) & core_done & ~abort;

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (accept) state_nx = LOAD;
      LOAD:    if (accept && byte_cnt == LAST && oper_idx == OPER_N) state_nx = START;
      START:   state_nx = WAIT;
      WAIT: begin
        if (core_done)    state_nx = UNLOAD;
        else if (timeout) state_nx = IDLE;
      end
      UNLOAD:  if (ser_done) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (abort) state_nx = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      in_ready_q   <= 1'b0;
      core_start_q <= 1'b0;
    end else begin
      state        <= state_nx;
      in_ready_q   <= (state_nx == IDLE) || (state_nx == LOAD);
      core_start_q <= (state == START) & ~abort;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      oper_idx <= OPER_C;
      byte_cnt <= '0;
    end else if (abort || (state != IDLE && state_nx == IDLE)) begin
      oper_idx <= OPER_C;
      byte_cnt <= '0;
    end else if (accept) begin
      if (byte_cnt == LAST) begin
        byte_cnt <= '0;
        oper_idx <= (oper_idx == OPER_N) ? OPER_C : oper_idx + 2'd1;
      end else begin
        byte_cnt <= byte_cnt + 1'b1;
      end
    end
  end

`ifdef RSA_SEQ_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] wait_cnt;
  logic          err_q;

  assign timeout = (state == WAIT) & ~core_done & (wait_cnt == TW'(TIMEOUT_CYCLES - 1));
  assign err     = err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= '0;
      err_q    <= 1'b0;
    end else begin
      wait_cnt <= (state == WAIT && !abort) ? wait_cnt + 1'b1 : '0;
      err_q    <= timeout & ~abort;
    end
  end
`else
  assign timeout = 1'b0;
  assign err     = 1'b0;
`endif

  rsa_result_serializer #(
    .DATA_W (DATA_W),
    .OPER_W (OPER_W)
  ) u_ser (
    .clk         (clk),
    .rst_n       (rst_n),
    .abort       (abort),
    .load        (ser_load),
    .core_result (core_result),
    .active      (state == UNLOAD),
    .out_ready   (out_ready),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .done        (ser_done)
  );

endmodule

// File: tb/tb_rsa_operand_sequencer.sv
// Directed self-checking bench for rsa_operand_sequencer (8-bit bytes, 512-bit operands).
module tb_rsa_operand_sequencer;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         abort = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [7:0]   in_data = '0;
  logic [2:0]   shift_en;
  logic [7:0]   shift_data;
  logic         core_start;
  logic         core_done = 1'b0;
  logic [511:0] core_result = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [7:0]   out_data;
  logic         busy;
  logic         err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rsa_operand_sequencer #(
    .DATA_W         (8),
    .OPER_W         (512),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .abort       (abort),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .shift_en    (shift_en),
    .shift_data  (shift_data),
    .core_start  (core_start),
    .core_done   (core_done),
    .core_result (core_result),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .busy        (busy),
    .err         (err)
  );

  typedef struct {
    logic       in_valid;
    logic       abort;
    logic [7:0] data;
    logic [2:0] exp_en;
    logic       exp_ready;
    logic       exp_busy;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] pat(input int sel, input int k);
    logic [7:0] kb;
    kb = 8'(k);
    case (sel)
      0:       return kb + 8'd1;
      1:       return kb ^ 8'hC0;
      default: return 8'hFF - kb;
    endcase
  endfunction

  // Feeds bytes 0..n-1 with in_valid high, checking the operand steering of each.
  task automatic load(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = 8'(i);
      abort    = 1'b0;
      #1;
      chk("load_in_ready", 64'(in_ready), 64'd1);
      chk("load_shift_en", 64'(shift_en), 64'(3'b001 << (i / 64)));
      chk("load_shift_data", 64'(shift_data), 64'(i[7:0]));
    end
  endtask

  // Full 192-byte load followed by the start pulse; returns in the first cycle after core_start.
  task automatic load_all();
    load(192);
    @(negedge clk);
    #1;
    chk("post_load_in_ready", 64'(in_ready), 64'd0);
    chk("post_load_no_shift", 64'(shift_en), 64'd0);
    chk("start_not_yet", 64'(core_start), 64'd0);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk("core_start_pulse", 64'(core_start), 64'd1);
    @(negedge clk);
    #1;
    chk("core_start_single", 64'(core_start), 64'd0);
    chk("busy_in_wait", 64'(busy), 64'd1);
  endtask

  task automatic unload(input bit toggle, input int sel);
    int k;
    int cyc;
    for (int b = 0; b < 64; b++) core_result[511 - 8*b -: 8] = pat(sel, b);
    @(negedge clk);
    core_done = 1'b1;
    #1;
    chk("out_valid_before_done", 64'(out_valid), 64'd0);
    k = 0;
    cyc = 0;
    while (k < 64 && cyc < 300) begin
      @(negedge clk);
      core_done = 1'b0;
      out_ready = toggle ? cyc[0] : 1'b1;
      #1;
      chk("out_valid", 64'(out_valid), 64'd1);
      chk("out_data", 64'(out_data), 64'(pat(sel, k)));
      if (out_ready) k++;
      cyc++;
    end
    chk("unload_byte_count", 64'(k), 64'd64);
    @(negedge clk);
    out_ready = 1'b0;
    #1;
    chk("out_valid_after_last", 64'(out_valid), 64'd0);
    chk("busy_after_last", 64'(busy), 64'd0);
    chk("in_ready_after_last", 64'(in_ready), 64'd1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    bit seen;

    vecs[0] = '{1'b0, 1'b0, 8'h00, 3'b000, 1'b1, 1'b0};
    vecs[1] = '{1'b1, 1'b0, 8'hA0, 3'b001, 1'b1, 1'b0};
    vecs[2] = '{1'b1, 1'b1, 8'hA1, 3'b000, 1'b1, 1'b1};
    vecs[3] = '{1'b0, 1'b0, 8'h00, 3'b000, 1'b1, 1'b0};
    vecs[4] = '{1'b1, 1'b0, 8'hA2, 3'b001, 1'b1, 1'b0};
    vecs[5] = '{1'b0, 1'b0, 8'h00, 3'b000, 1'b1, 1'b1};
    vecs[6] = '{1'b0, 1'b1, 8'h00, 3'b000, 1'b1, 1'b1};
    vecs[7] = '{1'b1, 1'b0, 8'hA3, 3'b001, 1'b1, 1'b0};
    vecs[8] = '{1'b0, 1'b1, 8'h00, 3'b000, 1'b1, 1'b1};
    vecs[9] = '{1'b0, 1'b0, 8'h00, 3'b000, 1'b1, 1'b0};

    // Reset state
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_core_start", 64'(core_start), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_shift_en", 64'(shift_en), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    chk("in_ready_after_rst", 64'(in_ready), 64'd1);

    // Short handshake/abort vectors from IDLE
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      in_valid = vecs[i].in_valid;
      abort    = vecs[i].abort;
      in_data  = vecs[i].data;
      #1;
      chk("vec_shift_en", 64'(shift_en), 64'(vecs[i].exp_en));
      chk("vec_in_ready", 64'(in_ready), 64'(vecs[i].exp_ready));
      chk("vec_busy", 64'(busy), 64'(vecs[i].exp_busy));
      chk("vec_shift_data", 64'(shift_data), 64'(vecs[i].data));
    end
    @(negedge clk);
    in_valid = 1'b0;
    abort    = 1'b0;

    // core_done outside WAIT is ignored
    core_result = '1;
    core_done   = 1'b1;
    @(negedge clk);
    core_done = 1'b0;
    #1;
    chk("idle_done_ignored_valid", 64'(out_valid), 64'd0);
    chk("idle_done_ignored_busy", 64'(busy), 64'd0);

    // Full transaction, then one with a stalling consumer
    load_all();
    unload(1'b0, 0);
    load_all();
    unload(1'b1, 1);

    // Abort mid operand D, then reload from C and abort in WAIT
    load(101);
    @(negedge clk);
    in_valid = 1'b0;
    abort    = 1'b1;
    #1;
    chk("abort_d_shift_en", 64'(shift_en), 64'd0);
    chk("abort_d_busy", 64'(busy), 64'd1);
    @(negedge clk);
    abort = 1'b0;
    #1;
    chk("abort_d_idle", 64'(busy), 64'd0);
    chk("abort_d_in_ready", 64'(in_ready), 64'd1);
    load_all();
    @(negedge clk);
    abort = 1'b1;
    #1;
    @(negedge clk);
    abort = 1'b0;
    #1;
    chk("abort_wait_idle", 64'(busy), 64'd0);
    chk("abort_wait_no_valid", 64'(out_valid), 64'd0);

    // Abort coincident with byte 63
    load(63);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 8'd63;
    abort    = 1'b1;
    #1;
    chk("abort_b63_shift_en", 64'(shift_en), 64'd0);
    @(negedge clk);
    in_valid = 1'b0;
    abort    = 1'b0;
    #1;
    chk("abort_b63_idle", 64'(busy), 64'd0);

    // Reload then let WAIT run without core_done
    load_all();
    c = 1;
    seen = 1'b0;
    while (c < 40 && !seen) begin
      if (err) seen = 1'b1;
      else begin
        @(negedge clk);
        #1;
        c++;
      end
    end
`ifdef RSA_SEQ_TIMEOUT_EN
    chk("timeout_seen", 64'(seen), 64'd1);
    chk("timeout_cycles", 64'(c), 64'd16);
    chk("timeout_idle", 64'(busy), 64'd0);
    @(negedge clk);
    #1;
    chk("err_single", 64'(err), 64'd0);
`else
    chk("no_timeout_err", 64'(seen), 64'd0);
    chk("still_waiting", 64'(busy), 64'd1);
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    #1;
    chk("final_abort_idle", 64'(busy), 64'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
